// File: rtl/cmd_port_bridge_if.sv
// cmd_port_bridge_if
//   Groups the host byte link and the PicoBlaze port bus of cmd_port_bridge.
//   Host link : rx_data/rx_strobe in, tx_data/tx_valid out, tx_ready in.
//   Port bus  : port_id, port_out, write_strobe, read_strobe, interrupt_ack in;
//               port_in, interrupt out.
//   The slave modport is the bridge's view; the master modport is the view of
//   whatever drives the link and the processor side (a testbench, for example).
interface cmd_port_bridge_if;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] port_id;
    logic [7:0] port_out;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] port_in;
    logic       interrupt;
    logic       interrupt_ack;

    modport slave (
        input  rx_data, rx_strobe, tx_ready,
        input  port_id, port_out, write_strobe, read_strobe, interrupt_ack,
        output tx_data, tx_valid, port_in, interrupt
    );

    modport master (
        output rx_data, rx_strobe, tx_ready,
        output port_id, port_out, write_strobe, read_strobe, interrupt_ack,
        input  tx_data, tx_valid, port_in, interrupt
    );
endinterface

// File: rtl/cmd_port_bridge.sv
// cmd_port_bridge
//   PicoBlaze I/O peripheral that sits between the host byte link and the
//   command_control processor. Incoming host bytes are buffered in an RX FIFO,
//   outgoing response bytes in a TX FIFO. Status, RX data, TX data and
//   interrupt-control registers are reachable through the port bus, and an
//   interrupt is raised when command bytes arrive.
//
// Ports
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : cmd_port_bridge_if.slave (host link + PicoBlaze port bus)
//
// Interrupt FSM
//   state | meaning
//   IDLE  | no request outstanding; arms when enabled and RX holds data
//   PEND  | interrupt asserted, waiting for interrupt_ack
//   WAIT  | acknowledged; held off until RX drains or irq_en drops
module cmd_port_bridge #(
    parameter int         DEPTH_LOG2    = 4,
    parameter logic [7:0] PORT_STATUS   = 8'h00,
    parameter logic [7:0] PORT_RX_DATA  = 8'h01,
    parameter logic [7:0] PORT_TX_DATA  = 8'h02,
    parameter logic [7:0] PORT_IRQ_CTRL = 8'h03
) (
    input  logic            clk,
    input  logic            reset_n,
    cmd_port_bridge_if.slave bus
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_PEND = 2'd1,
        IRQ_WAIT = 2'd2
    } irq_state_t;

    // ------------------------------------------------------------------
    // Port bus decode
    // ------------------------------------------------------------------
    logic rx_pop_req;
    logic tx_push_req;
    logic irq_ctrl_wr;

    assign rx_pop_req  = bus.read_strobe  && (bus.port_id == PORT_RX_DATA);
    assign tx_push_req = bus.write_strobe && (bus.port_id == PORT_TX_DATA);
    assign irq_ctrl_wr = bus.write_strobe && (bus.port_id == PORT_IRQ_CTRL);

    // ------------------------------------------------------------------
    // RX FIFO (host -> processor)
    // ------------------------------------------------------------------
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_count;
    logic [DEPTH_LOG2:0]   rx_count_next;
    logic                  rx_empty;
    logic                  rx_full;
    logic                  rx_pop;
    logic                  rx_push;
    logic                  rx_ovf_set;
    logic [7:0]            rx_head;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == COUNT_FULL);
    assign rx_pop   = rx_pop_req && !rx_empty;
    // A pop in the same cycle frees the slot the full FIFO needs.
    assign rx_push    = bus.rx_strobe && (!rx_full || rx_pop);
    assign rx_ovf_set = bus.rx_strobe && rx_full && !rx_pop;
    assign rx_head    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

    always_comb begin
        rx_count_next = rx_count;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count + COUNT_ONE;
            2'b01:   rx_count_next = rx_count - COUNT_ONE;
            default: rx_count_next = rx_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            end
            rx_count <= rx_count_next;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (processor -> host)
    // ------------------------------------------------------------------
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [DEPTH_LOG2:0]   tx_count;
    logic [DEPTH_LOG2:0]   tx_count_next;
    logic                  tx_empty;
    logic                  tx_full;
    logic                  tx_pop;
    logic                  tx_push;
    logic                  tx_drop_set;

    assign tx_empty    = (tx_count == '0);
    assign tx_full     = (tx_count == COUNT_FULL);
    assign tx_pop      = !tx_empty && bus.tx_ready;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop_set = tx_push_req && tx_full && !tx_pop;

    // Head is gated by valid so tx_data reads zero whenever nothing is queued.
    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

    always_comb begin
        tx_count_next = tx_count;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + COUNT_ONE;
            2'b01:   tx_count_next = tx_count - COUNT_ONE;
            default: tx_count_next = tx_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bus.port_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            end
            tx_count <= tx_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Control / sticky flags
    // ------------------------------------------------------------------
    logic irq_en;
    logic rx_ovf;
    logic tx_drop;
    logic flag_clr;

    assign flag_clr = irq_ctrl_wr && bus.port_out[1];

    // A fresh overflow in the clearing cycle must survive the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en  <= 1'b0;
            rx_ovf  <= 1'b0;
            tx_drop <= 1'b0;
        end else begin
            if (irq_ctrl_wr) begin
                irq_en <= bus.port_out[0];
            end
            rx_ovf  <= (rx_ovf  && !flag_clr) || rx_ovf_set;
            tx_drop <= (tx_drop && !flag_clr) || tx_drop_set;
        end
    end

    // ------------------------------------------------------------------
    // Registered read mux: PicoBlaze presents port_id one cycle before
    // read_strobe, so registering here still lands in the strobe cycle.
    // ------------------------------------------------------------------
    logic [7:0] status;
    logic [7:0] read_mux;
    logic [7:0] port_in_q;

    assign status = {1'b0, tx_drop, irq_en, rx_ovf,
                     tx_full, !tx_empty, rx_full, !rx_empty};

    always_comb begin
        read_mux = 8'h00;
        if (bus.port_id == PORT_STATUS) begin
            read_mux = status;
        end else if (bus.port_id == PORT_RX_DATA) begin
            read_mux = rx_head;
        end else if (bus.port_id == PORT_IRQ_CTRL) begin
            read_mux = {7'b0, irq_en};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_in_q <= 8'h00;
        end else begin
            port_in_q <= read_mux;
        end
    end

    assign bus.port_in = port_in_q;

    // ------------------------------------------------------------------
    // Interrupt FSM. Arming looks at the RX occupancy after this cycle's
    // push/pop so a byte landing in an empty FIFO arms immediately.
    // ------------------------------------------------------------------
    irq_state_t irq_state;
    irq_state_t irq_state_next;
    logic       interrupt_q;

    always_comb begin
        irq_state_next = irq_state;
        case (irq_state)
            IRQ_IDLE: begin
                if (irq_en && (rx_count_next != '0)) begin
                    irq_state_next = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                if (!irq_en) begin
                    irq_state_next = IRQ_IDLE;
                end else if (bus.interrupt_ack) begin
                    irq_state_next = IRQ_WAIT;
                end
            end
            IRQ_WAIT: begin
                if (!irq_en || (rx_count_next == '0)) begin
                    irq_state_next = IRQ_IDLE;
                end
            end
            default: irq_state_next = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_state <= IRQ_IDLE;
        end else begin
            irq_state <= irq_state_next;
        end
    end

    // The request line is asserted while PEND persists, and drops on the
    // edge that leaves PEND (ack or irq_en cleared).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interrupt_q <= 1'b0;
        end else begin
            interrupt_q <= (irq_state == IRQ_PEND) && (irq_state_next == IRQ_PEND);
        end
    end

    assign bus.interrupt = interrupt_q;

endmodule
